graph_mem_server: RTL and testbench

//  Responder side of graph_fetch's memory/visited interface. Holds the graph image (vertex records:

---
 rtl/graph_mem_pkg.sv | 32 +++
 rtl/graph_mem_server_if.sv | 40 ++++
 rtl/graph_mem_server_visited_table.sv | 90 +++++++++
 rtl/graph_mem_server.sv | 89 ++++++++
 tb/tb_graph_mem_server.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/graph_mem_pkg.sv
// Shared types and constants for the graph memory server and its fetch engines.
package graph_mem_pkg;

    localparam int unsigned DEFAULT_DEPTH  = 4096;
    localparam int unsigned DEFAULT_VDEPTH = 4096;
    localparam int unsigned DIM            = 2;

    typedef logic [31:0] word_t;

    // Vertex record: header, DIM position words, then a 0-terminated neighbor list
    localparam word_t NULL_NEIGH   = 32'd0;
    localparam word_t POS_OFFSET   = 32'd1;
    localparam word_t NEIGH_OFFSET = 32'(1 + DIM);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_e;

    function automatic word_t pos_addr(word_t base, int unsigned d);
        return base + POS_OFFSET + 32'(d);
    endfunction

    function automatic word_t neigh_addr(word_t base, int unsigned k);
        return base + NEIGH_OFFSET + 32'(k);
    endfunction

    function automatic logic is_list_end(word_t w);
        return w == NULL_NEIGH;
    endfunction

endpackage

// File: rtl/graph_mem_server_if.sv
// Memory, loader and visited-table signals between graph_mem_server and its clients.
interface graph_mem_server_if;
    import graph_mem_pkg::*;

    logic  mem_valid_in;
    word_t mem_req_in;
    logic  mem_valid_out;
    word_t mem_data_out;
    logic  mem_valid_in2;
    word_t mem_req_in2;
    logic  mem_valid_out2;
    word_t mem_data_out2;
    logic  load_valid_in;
    word_t load_addr_in;
    word_t load_data_in;
    logic  load_ready_out;
    logic  visited_req_valid_in;
    word_t visited_req_in;
    logic  visited_val_out;
    logic  visited_val_valid_out;
    logic  visited_clear_in;
    logic  clear_busy_out;

    modport master (
        output mem_valid_in, mem_req_in, mem_valid_in2, mem_req_in2,
               load_valid_in, load_addr_in, load_data_in,
               visited_req_valid_in, visited_req_in, visited_clear_in,
        input  mem_valid_out, mem_data_out, mem_valid_out2, mem_data_out2,
               load_ready_out, visited_val_out, visited_val_valid_out, clear_busy_out
    );

    modport slave (
        input  mem_valid_in, mem_req_in, mem_valid_in2, mem_req_in2,
               load_valid_in, load_addr_in, load_data_in,
               visited_req_valid_in, visited_req_in, visited_clear_in,
        output mem_valid_out, mem_data_out, mem_valid_out2, mem_data_out2,
               load_ready_out, visited_val_out, visited_val_valid_out, clear_busy_out
    );

endinterface

// File: rtl/graph_mem_server_visited_table.sv
// Visited bitmap with single-cycle read-modify-write and a word-per-cycle clear sweep.
// VISITED_TAS_EN: queries test-and-set; otherwise only bit-31 "mark" queries set the bit.
module visited_table
    import graph_mem_pkg::*;
#(
    parameter int unsigned VDEPTH = DEFAULT_VDEPTH
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  req_valid,
    input  word_t req_addr,
    input  logic  clear,
    output logic  val,
    output logic  val_valid,
    output logic  busy
);

    localparam int unsigned VW = $clog2(VDEPTH);
    localparam int unsigned NW = VDEPTH / 32;
    localparam int unsigned WW = $clog2(NW);

    logic [31:0]    bits [NW];
    clear_state_e   state;
    logic [WW-1:0]  clr_idx;
    logic [VW-1:0]  idx;
    logic [WW-1:0]  w_idx;
    logic [4:0]     b_idx;
    logic [31:0]    cur_word;
    logic           cur_bit;
    logic           in_range;
    logic           set_req;
    logic           upd;

    assign idx      = req_addr[VW-1:0];
    assign w_idx    = idx[VW-1:5];
    assign b_idx    = idx[4:0];
    assign cur_word = bits[w_idx];
    assign cur_bit  = cur_word[b_idx];

`ifdef VISITED_TAS_EN
    assign in_range = req_addr < 32'(VDEPTH);
    assign set_req  = 1'b1;
`else
    assign in_range = {1'b0, req_addr[30:0]} < 32'(VDEPTH);
    assign set_req  = req_addr[31];
`endif

    assign upd  = req_valid && in_range && set_req && (state == IDLE);
    assign busy = (state == CLEAR);

    // Update is written on the query edge, so a back-to-back query already sees it
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            bits[clr_idx] <= '0;
        end else if (upd) begin
            bits[w_idx] <= cur_word | (32'd1 << b_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_idx   <= '0;
            val       <= 1'b0;
            val_valid <= 1'b0;
        end else begin
            val_valid <= req_valid;
            val       <= req_valid && (state == IDLE) && (!in_range || cur_bit);
            case (state)
                IDLE: begin
                    if (clear) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
                CLEAR: begin
                    if (clear) begin
                        clr_idx <= '0;
                    end else if (clr_idx == WW'(NW - 1)) begin
                        state <= IDLE;
                    end else begin
                        clr_idx <= clr_idx + WW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/graph_mem_server.sv
// Graph image BRAM with two fixed-latency read channels, host loader and visited table.
// VISITED_TAS_EN selects test-and-set visited queries (see visited_table).
module graph_mem_server
    import graph_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned VDEPTH = DEFAULT_VDEPTH
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    graph_mem_server_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    word_t          mem [DEPTH];
    word_t          a_q;
    word_t          b_q;
    logic           rst_done;
    logic           a_rd_v;
    logic           b_rd_v;
    logic           a_oor;
    logic           b_oor;
    logic [AW-1:0]  a_idx;
    logic [AW-1:0]  b_idx;
    logic [AW-1:0]  l_idx;
    logic           a_in;
    logic           b_in;
    logic           l_in;
    logic           load_fire;

    assign a_idx = bus.mem_req_in[AW-1:0];
    assign b_idx = bus.mem_req_in2[AW-1:0];
    assign l_idx = bus.load_addr_in[AW-1:0];
    assign a_in  = bus.mem_req_in   < 32'(DEPTH);
    assign b_in  = bus.mem_req_in2  < 32'(DEPTH);
    assign l_in  = bus.load_addr_in < 32'(DEPTH);

    // Loader borrows port A only in cycles without a channel A read
    assign bus.load_ready_out = rst_done && !bus.mem_valid_in;
    assign load_fire          = bus.load_valid_in && bus.load_ready_out;

    // Synchronous BRAM read; port B sees pre-write data on a same-edge write
    always_ff @(posedge clk_in) begin
        if (load_fire && l_in) begin
            mem[l_idx] <= bus.load_data_in;
        end
        a_q <= mem[a_idx];
        b_q <= mem[b_idx];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_done           <= 1'b0;
            a_rd_v             <= 1'b0;
            b_rd_v             <= 1'b0;
            a_oor              <= 1'b0;
            b_oor              <= 1'b0;
            bus.mem_valid_out  <= 1'b0;
            bus.mem_data_out   <= '0;
            bus.mem_valid_out2 <= 1'b0;
            bus.mem_data_out2  <= '0;
        end else begin
            rst_done           <= 1'b1;
            a_rd_v             <= bus.mem_valid_in;
            b_rd_v             <= bus.mem_valid_in2;
            a_oor              <= !a_in;
            b_oor              <= !b_in;
            bus.mem_valid_out  <= a_rd_v;
            bus.mem_data_out   <= (a_rd_v && !a_oor) ? a_q : NULL_NEIGH;
            bus.mem_valid_out2 <= b_rd_v;
            bus.mem_data_out2  <= (b_rd_v && !b_oor) ? b_q : NULL_NEIGH;
        end
    end

    visited_table #(
        .VDEPTH (VDEPTH)
    ) u_visited (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .req_valid (bus.visited_req_valid_in),
        .req_addr  (bus.visited_req_in),
        .clear     (bus.visited_clear_in),
        .val       (bus.visited_val_out),
        .val_valid (bus.visited_val_valid_out),
        .busy      (bus.clear_busy_out)
    );

endmodule

// File: tb/tb_graph_mem_server.sv
// Directed self-checking bench for graph_mem_server: reads, loads, visited table, clear, reset.
module tb_graph_mem_server;
    import graph_mem_pkg::*;

    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned VDEPTH = 4096;
    localparam int          NW     = 128;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    graph_mem_server_if bus ();

    graph_mem_server dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_valid_in         = 1'b0;
        bus.mem_req_in           = '0;
        bus.mem_valid_in2        = 1'b0;
        bus.mem_req_in2          = '0;
        bus.load_valid_in        = 1'b0;
        bus.load_addr_in         = '0;
        bus.load_data_in         = '0;
        bus.visited_req_valid_in = 1'b0;
        bus.visited_req_in       = '0;
        bus.visited_clear_in     = 1'b0;
    endtask

    task automatic do_load(input word_t addr, input word_t data);
        bus.load_valid_in = 1'b1;
        bus.load_addr_in  = addr;
        bus.load_data_in  = data;
        #1;
        tests++;
        if (bus.load_ready_out !== 1'b1) begin
            fails++;
            $display("FAIL load_ready idle: got %b want 1", bus.load_ready_out);
        end
        step();
        bus.load_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) step();
        tests++;
        if ({bus.mem_valid_out, bus.mem_valid_out2, bus.visited_val_valid_out,
             bus.visited_val_out, bus.load_ready_out} !== 5'b0) begin
            fails++;
            $display("FAIL reset outputs: got %b want 00000",
                     {bus.mem_valid_out, bus.mem_valid_out2, bus.visited_val_valid_out,
                      bus.visited_val_out, bus.load_ready_out});
        end
        tests++;
        if (bus.mem_data_out !== 32'd0 || bus.mem_data_out2 !== 32'd0) begin
            fails++;
            $display("FAIL reset data: got %h %h want 0 0", bus.mem_data_out, bus.mem_data_out2);
        end
        tests++;
        if (bus.clear_busy_out !== 1'b1) begin
            fails++;
            $display("FAIL reset busy: got %b want 1", bus.clear_busy_out);
        end
        rst_n = 1'b1;
        n = 0;
        while (bus.clear_busy_out === 1'b1 && n < 300) begin
            step();
            n++;
        end
        tests++;
        if (n !== NW) begin
            fails++;
            $display("FAIL reset clear length: got %0d cycles want %0d", n, NW);
        end
        tests++;
        if (bus.load_ready_out !== 1'b1) begin
            fails++;
            $display("FAIL ready after reset: got %b want 1", bus.load_ready_out);
        end
    endtask

    task automatic test_load_read();
        do_load(pos_addr(32'd4, 0), 32'd100);
        do_load(pos_addr(32'd4, 1), 32'd0);
        bus.mem_valid_in = 1'b1;
        bus.mem_req_in   = 32'd5;
        step();
        bus.mem_valid_in = 1'b0;
        tests++;
        if (bus.mem_valid_out !== 1'b0) begin
            fails++;
            $display("FAIL read t+1 early valid: got %b want 0", bus.mem_valid_out);
        end
        step();
        tests++;
        if (bus.mem_valid_out !== 1'b1 || bus.mem_data_out !== 32'd100) begin
            fails++;
            $display("FAIL read A@5 t+2: got v=%b d=%0d want v=1 d=100",
                     bus.mem_valid_out, bus.mem_data_out);
        end
        step();
        tests++;
        if (bus.mem_valid_out !== 1'b0) begin
            fails++;
            $display("FAIL read t+3 valid: got %b want 0", bus.mem_valid_out);
        end
    endtask

    task automatic test_dual_channel();
        bus.mem_valid_in  = 1'b1;
        bus.mem_req_in    = 32'd5;
        bus.mem_valid_in2 = 1'b1;
        bus.mem_req_in2   = 32'd6;
        step();
        bus.mem_valid_in  = 1'b0;
        bus.mem_valid_in2 = 1'b0;
        step();
        tests++;
        if (bus.mem_valid_out !== 1'b1 || bus.mem_data_out !== 32'd100 ||
            bus.mem_valid_out2 !== 1'b1 || !is_list_end(bus.mem_data_out2)) begin
            fails++;
            $display("FAIL dual A@5 B@6: got A v=%b d=%0d B v=%b d=%0d want 1/100 1/0",
                     bus.mem_valid_out, bus.mem_data_out, bus.mem_valid_out2, bus.mem_data_out2);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) do_load(32'(20 + i), 32'(11 + i));
        for (int c = 0; c < 6; c++) begin
            bus.mem_valid_in = (c < 4);
            bus.mem_req_in   = 32'(20 + c);
            step();
            tests++;
            if (bus.mem_valid_out !== (c >= 1 && c <= 4)) begin
                fails++;
                $display("FAIL b2b valid c=%0d: got %b want %b", c, bus.mem_valid_out, (c >= 1 && c <= 4));
            end
            if (c >= 1 && c <= 4) begin
                tests++;
                if (bus.mem_data_out !== 32'(11 + c - 1)) begin
                    fails++;
                    $display("FAIL b2b data c=%0d: got %0d want %0d", c, bus.mem_data_out, 11 + c - 1);
                end
            end
        end
        bus.mem_valid_in = 1'b0;
    endtask

    task automatic test_out_of_range_and_collision();
        bus.mem_valid_in  = 1'b1;
        bus.mem_req_in    = 32'(DEPTH);
        bus.mem_valid_in2 = 1'b1;
        bus.mem_req_in2   = 32'hFFFF_FFFF;
        step();
        bus.mem_valid_in  = 1'b0;
        bus.mem_valid_in2 = 1'b0;
        step();
        tests++;
        if (bus.mem_valid_out !== 1'b1 || bus.mem_data_out !== 32'd0 ||
            bus.mem_valid_out2 !== 1'b1 || bus.mem_data_out2 !== 32'd0) begin
            fails++;
            $display("FAIL out of range: got A v=%b d=%h B v=%b d=%h want 1/0 1/0",
                     bus.mem_valid_out, bus.mem_data_out, bus.mem_valid_out2, bus.mem_data_out2);
        end
        // read collides with a held load; the load must wait a cycle
        bus.mem_valid_in  = 1'b1;
        bus.mem_req_in    = 32'd5;
        bus.load_valid_in = 1'b1;
        bus.load_addr_in  = 32'd30;
        bus.load_data_in  = 32'd55;
        #1;
        tests++;
        if (bus.load_ready_out !== 1'b0) begin
            fails++;
            $display("FAIL collision ready: got %b want 0", bus.load_ready_out);
        end
        step();
        bus.mem_valid_in = 1'b0;
        #1;
        tests++;
        if (bus.load_ready_out !== 1'b1) begin
            fails++;
            $display("FAIL held load ready: got %b want 1", bus.load_ready_out);
        end
        step();
        bus.load_valid_in = 1'b0;
        tests++;
        if (bus.mem_valid_out !== 1'b1 || bus.mem_data_out !== 32'd100) begin
            fails++;
            $display("FAIL collision read: got v=%b d=%0d want 1/100", bus.mem_valid_out, bus.mem_data_out);
        end
        bus.mem_valid_in = 1'b1;
        bus.mem_req_in   = 32'd30;
        step();
        bus.mem_valid_in = 1'b0;
        step();
        tests++;
        if (bus.mem_valid_out !== 1'b1 || bus.mem_data_out !== 32'd55) begin
            fails++;
            $display("FAIL delayed load landed: got v=%b d=%0d want 1/55", bus.mem_valid_out, bus.mem_data_out);
        end
        do_load(32'(DEPTH + 3), 32'hDEAD);
    endtask

    task automatic test_read_first();
        do_load(32'd40, 32'd7);
        bus.load_valid_in = 1'b1;
        bus.load_addr_in  = 32'd40;
        bus.load_data_in  = 32'd9;
        bus.mem_valid_in2 = 1'b1;
        bus.mem_req_in2   = 32'd40;
        step();
        bus.load_valid_in = 1'b0;
        bus.mem_valid_in2 = 1'b0;
        step();
        tests++;
        if (bus.mem_valid_out2 !== 1'b1 || bus.mem_data_out2 !== 32'd7) begin
            fails++;
            $display("FAIL read-first B@40: got v=%b d=%0d want 1/7", bus.mem_valid_out2, bus.mem_data_out2);
        end
        bus.mem_valid_in2 = 1'b1;
        step();
        bus.mem_valid_in2 = 1'b0;
        step();
        tests++;
        if (bus.mem_data_out2 !== 32'd9) begin
            fails++;
            $display("FAIL write after read-first: got %0d want 9", bus.mem_data_out2);
        end
    endtask

    task automatic test_visited();
        logic exp9;
`ifdef VISITED_TAS_EN
        bus.visited_req_in = 32'd7;
        exp9 = 1'b1;
`else
        bus.visited_req_in = 32'h8000_0007;
        exp9 = 1'b0;
`endif
        bus.visited_req_valid_in = 1'b1;
        step();
        tests++;
        if (bus.visited_val_valid_out !== 1'b1 || bus.visited_val_out !== 1'b0) begin
            fails++;
            $display("FAIL visited first q7: got v=%b val=%b want 1/0",
                     bus.visited_val_valid_out, bus.visited_val_out);
        end
        bus.visited_req_in = 32'd7;
        step();
        tests++;
        if (bus.visited_val_valid_out !== 1'b1 || bus.visited_val_out !== 1'b1) begin
            fails++;
            $display("FAIL visited second q7: got v=%b val=%b want 1/1",
                     bus.visited_val_valid_out, bus.visited_val_out);
        end
        bus.visited_req_in = 32'd9;
        step();
        step();
        tests++;
        if (bus.visited_val_out !== exp9) begin
            fails++;
            $display("FAIL visited q9 repeat: got %b want %b", bus.visited_val_out, exp9);
        end
        bus.visited_req_in = 32'(VDEPTH);
        step();
        tests++;
        if (bus.visited_val_out !== 1'b1) begin
            fails++;
            $display("FAIL visited out of range: got %b want 1", bus.visited_val_out);
        end
        bus.visited_req_valid_in = 1'b0;
        step();
        tests++;
        if (bus.visited_val_valid_out !== 1'b0) begin
            fails++;
            $display("FAIL visited idle valid: got %b want 0", bus.visited_val_valid_out);
        end
    endtask

    task automatic test_clear();
        int n;
        // query bit 7 (set earlier) together with the clear pulse: pre-clear answer
        bus.visited_req_valid_in = 1'b1;
        bus.visited_req_in       = 32'd7;
        bus.visited_clear_in     = 1'b1;
        step();
        bus.visited_clear_in = 1'b0;
        tests++;
        if (bus.visited_val_out !== 1'b1 || bus.clear_busy_out !== 1'b1) begin
            fails++;
            $display("FAIL query with clear: got val=%b busy=%b want 1/1",
                     bus.visited_val_out, bus.clear_busy_out);
        end
        bus.visited_req_in = 32'(VDEPTH);
        step();
        bus.visited_req_valid_in = 1'b0;
        tests++;
        if (bus.visited_val_valid_out !== 1'b1 || bus.visited_val_out !== 1'b0) begin
            fails++;
            $display("FAIL query during clear: got v=%b val=%b want 1/0",
                     bus.visited_val_valid_out, bus.visited_val_out);
        end
        n = 1;
        while (bus.clear_busy_out === 1'b1 && n < 300) begin
            step();
            n++;
        end
        tests++;
        if (n !== NW) begin
            fails++;
            $display("FAIL clear length: got %0d cycles want %0d", n, NW);
        end
        bus.visited_req_valid_in = 1'b1;
        bus.visited_req_in       = 32'd7;
        step();
        bus.visited_req_valid_in = 1'b0;
        tests++;
        if (bus.visited_val_valid_out !== 1'b1 || bus.visited_val_out !== 1'b0) begin
            fails++;
            $display("FAIL q7 after clear: got v=%b val=%b want 1/0",
                     bus.visited_val_valid_out, bus.visited_val_out);
        end
        // restart mid-sweep: a full sweep follows the second pulse
        bus.visited_clear_in = 1'b1;
        step();
        bus.visited_clear_in = 1'b0;
        repeat (10) step();
        bus.visited_clear_in = 1'b1;
        step();
        bus.visited_clear_in = 1'b0;
        n = 0;
        while (bus.clear_busy_out === 1'b1 && n < 300) begin
            step();
            n++;
        end
        tests++;
        if (n !== NW) begin
            fails++;
            $display("FAIL clear restart length: got %0d cycles want %0d", n, NW);
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        bus.mem_valid_in  = 1'b1;
        bus.mem_req_in    = 32'd5;
        bus.mem_valid_in2 = 1'b1;
        bus.mem_req_in2   = 32'd6;
        bus.visited_req_valid_in = 1'b1;
        bus.visited_req_in       = 32'd7;
        step();
        step();
        idle_inputs();
        tests++;
        if (bus.mem_valid_out !== 1'b1 || bus.mem_valid_out2 !== 1'b1) begin
            fails++;
            $display("FAIL pre-reset pipeline: got %b%b want 11", bus.mem_valid_out, bus.mem_valid_out2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.mem_valid_out, bus.mem_valid_out2, bus.visited_val_valid_out} !== 3'b000) begin
            fails++;
            $display("FAIL async reset valids: got %b want 000",
                     {bus.mem_valid_out, bus.mem_valid_out2, bus.visited_val_valid_out});
        end
        step();
        step();
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.mem_valid_out || bus.mem_valid_out2 || bus.visited_val_valid_out) stale++;
        end
        tests++;
        if (stale !== 0) begin
            fails++;
            $display("FAIL stale after reset: got %0d valid cycles want 0", stale);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_load_read();
        test_dual_channel();
        test_back_to_back();
        test_out_of_range_and_collision();
        test_read_first();
        test_visited();
        test_clear();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
